// File: rtl/uart_matrix_pkg.sv
// Shared constants and state encoding for the uart_matrix configuration controller.
// No ports; imported by uart_matrix_cfg.
package uart_matrix_pkg;

   localparam logic [7:0] SYNC      = 8'hA5;
   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_CLEAR = 8'h02;
   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] ACK       = 8'h06;
   localparam logic [7:0] NAK       = 8'h15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ROW,
      ST_DATA,
      ST_CHK,
      ST_CLEAR,
      ST_RESP
   } state_t;

endpackage

// File: rtl/uart_matrix_cfg_respq.sv
// Response byte queue for uart_matrix_cfg. Loaded in one shot with up to DEPTH
// bytes (byte 0 in push_data[7:0] goes out first), drained one byte per cycle.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   push             load push_data/push_len (only issued while the queue is empty)
//   push_data        DEPTH bytes, first byte in the low bits
//   push_len         number of valid bytes in push_data
//   en               drain permitted this cycle
//   full             downstream FIFO full; stalls draining
//   data, cke        head byte and its write strobe
//   empty            no bytes left
module uart_matrix_cfg_respq #(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [DEPTH*8-1:0]           push_data,
   input  logic [$clog2(DEPTH+1)-1:0]   push_len,
   input  logic                         en,
   input  logic                         full,
   output logic [7:0]                   data,
   output logic                         cke,
   output logic                         empty
);
   localparam int LW = $clog2(DEPTH + 1);

   logic [7:0]    q [DEPTH];
   logic [LW-1:0] cnt;

   assign empty = (cnt == '0);
   assign cke   = en && !empty && !full;
   assign data  = q[0];

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      end else if (push) begin
         cnt <= push_len;
         for (int i = 0; i < DEPTH; i++) q[i] <= push_data[i*8 +: 8];
      end else if (cke) begin
         cnt <= cnt - LW'(1);
         for (int i = 0; i < DEPTH - 1; i++) q[i] <= q[i+1];
         q[DEPTH-1] <= '0;
      end
   end

endmodule

// File: rtl/uart_matrix_cfg.sv
// Configuration controller for uart_matrix. Parses framed host commands
// (A5, CMD, ROW, [data bytes LSB first], CHK) and programs the routing LUT,
// keeping a shadow copy for readback; answers with ACK/NAK/readback bytes.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_data, in_cke     host byte and its strobe
//   lut_addr/data/cke   LUT row write port towards uart_matrix
//   resp, resp_cke      response byte and write strobe to the host TX FIFO
//   resp_full           TX FIFO full, holds responses back
//   busy                high while clearing or responding (input bytes dropped)
//   overrun             sticky: a byte was dropped while busy
//
// state | meaning
// IDLE  | hunting for the sync byte
// CMD   | waiting for the command byte
// ROW   | waiting for the row byte
// DATA  | collecting row data bytes
// CHK   | waiting for the checksum, then act on the frame
// CLEAR | zeroing LUT rows 1..m-1 (row 0 is written on leaving CHK)
// RESP  | draining the response queue
module uart_matrix_cfg #(
   parameter int m       = 8,
   parameter int n       = 8,
   parameter int TIMEOUT = 100000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   in_data,
   input  logic         in_cke,
   output logic [m-1:0] lut_addr,
   output logic [n-1:0] lut_data,
   output logic         lut_cke,
   output logic [7:0]   resp,
   output logic         resp_cke,
   input  logic         resp_full,
   output logic         busy,
   output logic         overrun
);
   import uart_matrix_pkg::*;

   localparam int NB = (n + 7) / 8;
   localparam int QD = NB + 1;
   localparam int RW = NB * 8;
   localparam int LW = $clog2(QD + 1);
   localparam int AW = (m > 1) ? $clog2(m) : 1;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t          state, state_nxt;
   logic [7:0]      cmd, cmd_nxt, row, row_nxt, chk, chk_nxt;
   logic [n-1:0]    data, data_nxt;
   logic [CW-1:0]   bcnt, bcnt_nxt;
   logic [TW-1:0]   tmo, tmo_nxt;
   logic [AW-1:0]   clr, clr_nxt;
   logic            lut_cke_nxt;
   logic [m-1:0]    lut_addr_nxt;
   logic [n-1:0]    lut_data_nxt;
   logic [n-1:0]    shadow [m];
   logic            sh_we;
   logic [AW-1:0]   sh_idx;
   logic [n-1:0]    sh_wd;
   logic            push;
   logic [QD*8-1:0] push_data;
   logic [LW-1:0]   push_len;
   logic            q_empty;
   logic [RW-1:0]   rd_bytes;
   logic [7:0]      rd_xor;

   assign busy = (state == ST_CLEAR) || (state == ST_RESP);

   always_comb begin
      state_nxt    = state;
      cmd_nxt      = cmd;
      row_nxt      = row;
      chk_nxt      = chk;
      data_nxt     = data;
      bcnt_nxt     = bcnt;
      tmo_nxt      = tmo;
      clr_nxt      = clr;
      lut_cke_nxt  = 1'b0;
      lut_addr_nxt = lut_addr;
      lut_data_nxt = lut_data;
      sh_we        = 1'b0;
      sh_idx       = row[AW-1:0];
      sh_wd        = data;
      push         = 1'b0;
      push_data    = '0;
      push_len     = '0;

      rd_bytes = RW'(shadow[row[AW-1:0]]);
      rd_xor   = '0;
      for (int i = 0; i < NB; i++) rd_xor = rd_xor ^ rd_bytes[i*8 +: 8];

      // Inter-byte timeout: any byte reloads, silence counts down to an abandon.
      if (state inside {ST_CMD, ST_ROW, ST_DATA, ST_CHK}) begin
         if (in_cke)            tmo_nxt   = TW'(TIMEOUT - 1);
         else if (tmo == '0)    state_nxt = ST_IDLE;
         else                   tmo_nxt   = tmo - TW'(1);
      end

      case (state)
         ST_IDLE: if (in_cke && in_data == SYNC) begin
            state_nxt = ST_CMD;
            tmo_nxt   = TW'(TIMEOUT - 1);
         end
         ST_CMD: if (in_cke) begin
            cmd_nxt = in_data;
            chk_nxt = in_data;
            if (in_data == CMD_WRITE || in_data == CMD_CLEAR || in_data == CMD_READ) begin
               state_nxt = ST_ROW;
            end else begin
               push      = 1'b1;
               push_data = (QD*8)'(NAK);
               push_len  = LW'(1);
               state_nxt = ST_RESP;
            end
         end
         ST_ROW: if (in_cke) begin
            row_nxt = in_data;
            chk_nxt = chk ^ in_data;
            if (cmd == CMD_WRITE) begin
               bcnt_nxt  = '0;
               data_nxt  = '0;
               state_nxt = ST_DATA;
            end else begin
               state_nxt = ST_CHK;
            end
         end
         ST_DATA: if (in_cke) begin
            chk_nxt = chk ^ in_data;
            // Bits beyond n-1 in the last byte simply have no destination.
            for (int b = 0; b < n; b++)
               if (b / 8 == int'(bcnt)) data_nxt[b] = in_data[b % 8];
            if (int'(bcnt) == NB - 1) state_nxt = ST_CHK;
            else                      bcnt_nxt  = bcnt + CW'(1);
         end
         ST_CHK: if (in_cke) begin
            state_nxt = ST_RESP;
            push      = 1'b1;
            push_data = (QD*8)'(ACK);
            push_len  = LW'(1);
            if (in_data != chk || (cmd != CMD_CLEAR && int'(row) >= m)) begin
               push_data = (QD*8)'(NAK);
            end else if (cmd == CMD_WRITE) begin
               lut_cke_nxt  = 1'b1;
               lut_addr_nxt = m'(row);
               lut_data_nxt = data;
               sh_we        = 1'b1;
            end else if (cmd == CMD_CLEAR) begin
               // Row 0 goes out now so the first lut_cke follows the CHK strobe directly.
               lut_cke_nxt  = 1'b1;
               lut_addr_nxt = '0;
               lut_data_nxt = '0;
               sh_we        = 1'b1;
               sh_idx       = '0;
               sh_wd        = '0;
               if (m > 1) begin
                  push      = 1'b0;
                  clr_nxt   = AW'(1);
                  state_nxt = ST_CLEAR;
               end
            end else begin
               push_data = {rd_xor, rd_bytes};
               push_len  = LW'(QD);
            end
         end
         ST_CLEAR: begin
            lut_cke_nxt  = 1'b1;
            lut_addr_nxt = m'(clr);
            lut_data_nxt = '0;
            sh_we        = 1'b1;
            sh_idx       = clr;
            sh_wd        = '0;
            if (int'(clr) == m - 1) begin
               push      = 1'b1;
               push_data = (QD*8)'(ACK);
               push_len  = LW'(1);
               state_nxt = ST_RESP;
            end else begin
               clr_nxt = clr + AW'(1);
            end
         end
         ST_RESP: if (q_empty) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         cmd      <= '0;
         row      <= '0;
         chk      <= '0;
         data     <= '0;
         bcnt     <= '0;
         tmo      <= '0;
         clr      <= '0;
         lut_cke  <= 1'b0;
         lut_addr <= '0;
         lut_data <= '0;
         overrun  <= 1'b0;
         for (int i = 0; i < m; i++) shadow[i] <= '0;
      end else begin
         state    <= state_nxt;
         cmd      <= cmd_nxt;
         row      <= row_nxt;
         chk      <= chk_nxt;
         data     <= data_nxt;
         bcnt     <= bcnt_nxt;
         tmo      <= tmo_nxt;
         clr      <= clr_nxt;
         lut_cke  <= lut_cke_nxt;
         lut_addr <= lut_addr_nxt;
         lut_data <= lut_data_nxt;
         overrun  <= overrun | (in_cke & busy);
         if (sh_we) shadow[sh_idx] <= sh_wd;
      end
   end

   // Draining waits while a LUT write is on the bus so responses trail the last write.
   uart_matrix_cfg_respq #(.DEPTH(QD)) u_respq (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .push_len  (push_len),
      .en        (state == ST_RESP && !lut_cke),
      .full      (resp_full),
      .data      (resp),
      .cke       (resp_cke),
      .empty     (q_empty)
   );

endmodule

// File: tb/tb_uart_matrix_cfg.sv
module tb_uart_matrix_cfg;
   localparam int M   = 8;
   localparam int N   = 12;
   localparam int TMO = 200;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [7:0]   in_data = '0;
   logic         in_cke = 1'b0;
   logic [M-1:0] lut_addr;
   logic [N-1:0] lut_data;
   logic         lut_cke;
   logic [7:0]   resp;
   logic         resp_cke;
   logic         resp_full = 1'b0;
   logic         busy;
   logic         overrun;

   int checks = 0;
   int errors = 0;
   bit rand_full = 1'b0;

   logic [M+N-1:0] exp_lut[$];
   logic [7:0]     exp_resp[$];
   int             model_sh [M];

   uart_matrix_cfg #(.m(M), .n(N), .TIMEOUT(TMO)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_cke    (in_cke),
      .lut_addr  (lut_addr),
      .lut_data  (lut_data),
      .lut_cke   (lut_cke),
      .resp      (resp),
      .resp_cke  (resp_cke),
      .resp_full (resp_full),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an output.
   initial forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
         if (lut_cke) begin
            if (exp_lut.size() == 0) begin
               checks++; errors++;
               $display("FAIL lut_unexpected: got addr %0h data %0h expected no write", lut_addr, lut_data);
            end else begin
               check("lut_write", {lut_addr, lut_data}, exp_lut.pop_front());
            end
            check("busy_during_lut", busy, 1);
         end
         if (resp_cke) begin
            check("resp_while_full", resp_full, 0);
            check("resp_with_lut", lut_cke, 0);
            if (exp_resp.size() == 0) begin
               checks++; errors++;
               $display("FAIL resp_unexpected: got %0h expected no byte", resp);
            end else begin
               check("resp_byte", resp, exp_resp.pop_front());
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (rand_full) resp_full = ($urandom_range(0, 3) == 0);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [7:0] good_chk(input logic [7:0] cmd, input logic [7:0] row,
                                           input logic [15:0] d);
      logic [7:0] c;
      c = cmd ^ row;
      if (cmd == 8'h01) c = c ^ d[7:0] ^ d[15:8];
      return c;
   endfunction

   // Reference model: what the host should observe for one frame.
   task automatic model_frame(input logic [7:0] cmd, input logic [7:0] row,
                              input logic [15:0] d, input logic [7:0] chk);
      int r, v, lo, hi;
      r = int'(row);
      if (cmd < 8'h01 || cmd > 8'h03) begin
         exp_resp.push_back(8'h15);
      end else if (chk != good_chk(cmd, row, d) || (cmd != 8'h02 && r >= M)) begin
         exp_resp.push_back(8'h15);
      end else if (cmd == 8'h01) begin
         v = int'(d) % (1 << N);
         model_sh[r] = v;
         exp_lut.push_back({M'(r), N'(v)});
         exp_resp.push_back(8'h06);
      end else if (cmd == 8'h02) begin
         for (int i = 0; i < M; i++) begin
            model_sh[i] = 0;
            exp_lut.push_back({M'(i), N'(0)});
         end
         exp_resp.push_back(8'h06);
      end else begin
         lo = model_sh[r] % 256;
         hi = model_sh[r] / 256;
         exp_resp.push_back(8'(lo));
         exp_resp.push_back(8'(hi));
         exp_resp.push_back(8'(lo ^ hi));
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      in_data = b;
      in_cke  = 1'b1;
      @(negedge clk);
      in_cke  = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   // Returns on the negedge right after the last byte was sampled.
   task automatic do_frame(input logic [7:0] cmd, input logic [7:0] row,
                           input logic [15:0] d, input logic [7:0] chk, input int gapmax);
      model_frame(cmd, row, d, chk);
      send_byte(8'hA5, $urandom_range(0, gapmax));
      if (cmd < 8'h01 || cmd > 8'h03) begin
         send_byte(cmd, 0);
      end else begin
         send_byte(cmd, $urandom_range(0, gapmax));
         send_byte(row, $urandom_range(0, gapmax));
         if (cmd == 8'h01) begin
            send_byte(d[7:0], $urandom_range(0, gapmax));
            send_byte(d[15:8], $urandom_range(0, gapmax));
         end
         send_byte(chk, 0);
      end
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while ((exp_lut.size() != 0 || exp_resp.size() != 0 || busy) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k >= 3000) begin
         errors++;
         $display("FAIL %s: got %0d lut / %0d resp outstanding expected 0", name,
                  exp_lut.size(), exp_resp.size());
         exp_lut.delete();
         exp_resp.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      logic [7:0]  c, r, k;
      logic [15:0] d;
      int          sel;

      for (int i = 0; i < M; i++) model_sh[i] = 0;
      repeat (3) @(negedge clk);
      check("rst_lut_cke", lut_cke, 0);
      check("rst_lut_addr", lut_addr, 0);
      check("rst_lut_data", lut_data, 0);
      check("rst_resp_cke", resp_cke, 0);
      check("rst_resp", resp, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // WRITE row 3 = F34; lut_cke on the cycle after the CHK strobe
      do_frame(8'h01, 8'h03, 16'h0F34, 8'h39, 1);
      check("wr_latency_cke", lut_cke, 1);
      check("wr_addr", lut_addr, 3);
      check("wr_data", lut_data, 12'hF34);
      @(negedge clk);
      check("wr_single_cycle", lut_cke, 0);
      wait_idle("wr_done");

      // bad checksum, row out of range
      do_frame(8'h01, 8'h03, 16'h0F34, 8'h00, 1);
      wait_idle("badchk_done");
      do_frame(8'h01, 8'h08, 16'h0F34, good_chk(8'h01, 8'h08, 16'h0F34), 1);
      wait_idle("badrow_done");

      // READ row 3 with the TX FIFO full for 5 cycles
      resp_full = 1'b1;
      do_frame(8'h03, 8'h03, 16'h0000, 8'h00, 1);
      for (int i = 0; i < 5; i++) begin
         check("rd_held_full", resp_cke, 0);
         @(negedge clk);
      end
      resp_full = 1'b0;
      wait_idle("rd_done");

      // CLEAR: 8 consecutive row writes with busy high
      do_frame(8'h02, 8'h00, 16'h0000, 8'h02, 1);
      for (int i = 0; i < M; i++) begin
         check("clr_cke", lut_cke, 1);
         check("clr_busy", busy, 1);
         @(negedge clk);
      end
      check("clr_end", lut_cke, 0);
      wait_idle("clr_done");

      // Overrun: bytes during CLEAR are dropped
      do_frame(8'h02, 8'h55, 16'h0000, good_chk(8'h02, 8'h55, 16'h0000), 1);
      repeat (2) @(negedge clk);
      send_byte(8'hA5, 0);
      send_byte(8'h03, 0);
      check("ovr_set", overrun, 1);
      wait_idle("ovr_done");
      check("ovr_sticky", overrun, 1);
      do_frame(8'h03, 8'h03, 16'h0000, 8'h00, 1);
      wait_idle("ovr_read_done");

      // Reset mid-CLEAR
      do_frame(8'h02, 8'h00, 16'h0000, 8'h02, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_clr_cke", lut_cke, 0);
      check("rst_mid_clr_busy", busy, 0);
      check("rst_mid_clr_ovr", overrun, 0);
      exp_lut.delete();
      exp_resp.delete();
      for (int i = 0; i < M; i++) model_sh[i] = 0;
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Timeout: abandoned partial frame, then a good frame
      send_byte(8'hA5, 0);
      send_byte(8'h01, 0);
      repeat (TMO + 5) @(negedge clk);
      check("tmo_busy", busy, 0);
      do_frame(8'h01, 8'h05, 16'h0ABC, good_chk(8'h01, 8'h05, 16'h0ABC), 1);
      wait_idle("tmo_done");

      // Randomized frames with random FIFO backpressure
      rand_full = 1'b1;
      for (int t = 0; t < 40; t++) begin
         sel = $urandom_range(0, 9);
         r   = 8'($urandom_range(0, 9));
         d   = 16'($urandom);
         if (sel <= 4)      c = 8'h01;
         else if (sel <= 7) c = 8'h03;
         else if (sel == 8) c = 8'h02;
         else               c = 8'($urandom_range(4, 255));
         k = good_chk(c, r, d);
         if ($urandom_range(0, 7) == 0) k = k ^ 8'(1 << $urandom_range(0, 7));
         do_frame(c, r, d, k, 3);
         wait_idle("rand_done");
      end
      rand_full = 1'b0;
      resp_full = 1'b0;

      for (int i = 0; i < M; i++) begin
         r = 8'(i);
         do_frame(8'h03, r, 16'h0000, good_chk(8'h03, r, 16'h0000), 1);
         wait_idle("final_read_done");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
